// File: rtl/hex_display_scan.sv
// Scanned N-digit hex 7-segment driver with frame-aligned double-buffered load.
// Optional: LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module hex_display_scan #(
  parameter int NDIGITS      = 8,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic                   load,
  output logic [6:0]             seg,
  output logic [NDIGITS-1:0]     an,
  output logic                   frame_done
);

  localparam int VW = 4 * NDIGITS;
  localparam int CW = $clog2(CLK_DIV);
  localparam int DW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CBLK = CW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DMAX = DW'(NDIGITS - 1);

  logic [CW-1:0]      cnt;
  logic [DW-1:0]      digit;
  logic [VW-1:0]      shown;
  logic [VW-1:0]      pending;
  logic               pend_valid;

  logic               slot_end;
  logic               wrap;
  logic               blank;
  logic               lz;
  logic [3:0]         nib;
  logic [6:0]         seg_n;
  logic [NDIGITS-1:0] an_n;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_end = (cnt == CMAX);
    wrap     = slot_end && (digit == DMAX);
    blank    = (BLANK_CYCLES != 0) && (cnt < CBLK);
    nib      = shown[{digit, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    lz       = (digit != '0) && ((shown >> {digit, 2'b00}) == '0);
`else
    lz       = 1'b0;
`endif
    an_n     = blank ? '1 : ~(NDIGITS'(1) << digit);
    seg_n    = (blank || lz) ? 7'b1111111 : hex7(nib);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      digit      <= '0;
      shown      <= '0;
      pending    <= '0;
      pend_valid <= 1'b0;
      seg        <= 7'b1111111;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      cnt        <= slot_end ? '0 : cnt + 1'b1;
      frame_done <= wrap;
      seg        <= seg_n;
      an         <= an_n;
      if (slot_end)
        digit <= (digit == DMAX) ? '0 : digit + 1'b1;
      if (load)
        pending <= value;
      // a load coinciding with the wrap bypasses the pending buffer
      if (wrap) begin
        if (load)
          shown <= value;
        else if (pend_valid)
          shown <= pending;
        pend_valid <= 1'b0;
      end else if (load) begin
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan (4 digits, 4 cycles/slot, 1 blank cycle).
// Expected segment codes come from a hand-written hex table.
module tb_hex_display_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int nerr = 0;
  int nchk = 0;

  localparam logic [6:0] DEC [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  hex_display_scan #(
    .NDIGITS(4),
    .CLK_DIV(4),
    .BLANK_CYCLES(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .value(value),
    .load(load),
    .seg(seg),
    .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
    logic [15:0] up;
    logic        lzb;
    up  = v >> (4 * d);
    lzb = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    lzb = (d > 0) && (up == 16'h0);
`endif
    return lzb ? 7'b1111111 : DEC[up[3:0]];
  endfunction

  // One full frame from slot 0 cnt 0; optional loads at in-frame ticks la/lb
  task automatic check_frame(input string tag, input logic [15:0] v,
                             input int la, input logic [15:0] lav,
                             input int lb, input logic [15:0] lbv);
    for (int t = 0; t < 16; t++) begin
      int d;
      d     = t / 4;
      load  = (t == la) || (t == lb);
      value = (t == la) ? lav : ((t == lb) ? lbv : 16'h0);
      tick();
      if (t % 4 == 0) begin
        check($sformatf("%s blank_an d%0d", tag, d), 32'(an), 32'hF);
        check($sformatf("%s blank_seg d%0d", tag, d), 32'(seg), 32'h7F);
      end else begin
        check($sformatf("%s an d%0d", tag, d), 32'(an),
              32'(~(4'b0001 << d) & 4'hF));
        check($sformatf("%s seg d%0d", tag, d), 32'(seg),
              32'(exp_seg(v, d)));
      end
      check($sformatf("%s fd t%0d", tag, t), 32'(frame_done),
            32'(t == 15));
    end
    load  = 1'b0;
    value = 16'h0;
  endtask

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    value = 16'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst an", 32'(an), 32'hF);
      check("rst seg", 32'(seg), 32'h7F);
      check("rst fd", 32'(frame_done), 32'h0);
    end
    reset = 1'b0;

    check_frame("f0", 16'h0000,  2, 16'h1A2F, -1, 16'h0);
    check_frame("f1", 16'h1A2F,  4, 16'h1111, 10, 16'h2222);
    check_frame("f2", 16'h2222,  3, 16'h1234, 15, 16'h00F0);
    check_frame("f3", 16'h00F0, -1, 16'h0,    -1, 16'h0);
    check_frame("f4", 16'h00F0,  7, 16'h0030, -1, 16'h0);
    check_frame("f5", 16'h0030,  5, 16'h7654, -1, 16'h0);
    check_frame("f6", 16'h7654,  0, 16'hEDCB, -1, 16'h0);
    check_frame("f7", 16'hEDCB, 12, 16'h9800, -1, 16'h0);
    check_frame("f8", 16'h9800, -1, 16'h0,    -1, 16'h0);

    // reset during digit 2 slot with a pending value outstanding
    for (int t = 0; t < 10; t++) begin
      load  = (t == 1);
      value = (t == 1) ? 16'h4321 : 16'h0;
      tick();
    end
    load  = 1'b0;
    value = 16'h0;
    check("mid an before rst", 32'(an), 32'hB);
    reset = 1'b1;
    tick();
    check("midrst an", 32'(an), 32'hF);
    check("midrst seg", 32'(seg), 32'h7F);
    check("midrst fd", 32'(frame_done), 32'h0);
    reset = 1'b0;
    check_frame("f9", 16'h0000, -1, 16'h0, -1, 16'h0);
    check_frame("f10", 16'h0000, -1, 16'h0, -1, 16'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
